// File: rtl/door_lock_ctrl.sv
// -----------------------------------------------------------------------------
// door_lock_ctrl
//   Keypad lock for the door sprite. On every entry into STAGE1/2/3 the door is
//   re-locked and a fresh 4-digit BCD code is collected from the keyboard
//   decoder. A matching code unlocks the door. A wrong code costs one try and
//   opens a feedback window (err_flash). Running out of tries raises code_fail.
//
// Ports
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   state      : game state (STAGE1=2, STAGE2=4, STAGE3=6 are the lock stages)
//   key_valid  : one-cycle pulse qualifying key_code
//   key_code   : 0..9 digit, 4'hC clear, anything else ignored
//   isLocked   : 1 = door drawn locked
//   door_open  : one-cycle pulse on successful unlock
//   code_fail  : one-cycle pulse when the last try is used up
//   err_flash  : high during the wrong-code feedback window
//   digit_cnt  : digits entered so far (0..4)
//   entry      : entered digits, BCD, first digit in [15:12] once complete
//   tries_left : remaining attempts
//
// FSM states
//   state    | meaning
//   IDLE     | not in a lock stage, keys ignored
//   ENTRY    | collecting digits
//   CHECK    | one cycle compare of the complete entry against the stage code
//   OPEN     | unlocked, waits for the stage to be left
//   ERROR    | wrong-code window, counts ERR_CYCLES cycles then back to ENTRY
//   FAILED   | tries exhausted, door stays locked until the stage changes
// -----------------------------------------------------------------------------
module door_lock_ctrl #(
    parameter logic [15:0] CODE1      = 16'h1234,
    parameter logic [15:0] CODE2      = 16'h4071,
    parameter logic [15:0] CODE3      = 16'h9527,
    parameter int unsigned MAX_TRIES  = 3,
    parameter int unsigned ERR_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  state,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        isLocked,
    output logic        door_open,
    output logic        code_fail,
    output logic        err_flash,
    output logic [2:0]  digit_cnt,
    output logic [15:0] entry,
    output logic [1:0]  tries_left
);

    localparam int unsigned ERR_W = $clog2(ERR_CYCLES + 1);
    localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERR_CYCLES - 1);
    localparam logic [1:0] TRIES_INIT = 2'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_OPEN,
        S_ERROR,
        S_FAILED
    } fsm_t;

    fsm_t             fsm_q,    fsm_d;
    logic [3:0]       state_q;
    logic             locked_q, locked_d;
    logic             open_q,   open_d;
    logic             fail_q,   fail_d;
    logic             err_q,    err_d;
    logic [2:0]       cnt_q,    cnt_d;
    logic [15:0]      entry_q,  entry_d;
    logic [1:0]       tries_q,  tries_d;
    logic [ERR_W-1:0] errcnt_q, errcnt_d;

    logic        in_stage;
    logic        stage_entry;
    logic        digit_key;
    logic        clear_key;
    logic [15:0] code_sel;

    assign in_stage    = (state == 4'd2) || (state == 4'd4) || (state == 4'd6);
    assign stage_entry = in_stage && (state != state_q);
    assign digit_key   = key_valid && (key_code <= 4'd9);
    assign clear_key   = key_valid && (key_code == 4'hC);

    always_comb begin
        case (state)
            4'd4:    code_sel = CODE2;
            4'd6:    code_sel = CODE3;
            default: code_sel = CODE1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q    <= S_IDLE;
            state_q  <= 4'd0;
            locked_q <= 1'b1;
            open_q   <= 1'b0;
            fail_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 3'd0;
            entry_q  <= 16'h0000;
            tries_q  <= TRIES_INIT;
            errcnt_q <= '0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state;
            locked_q <= locked_d;
            open_q   <= open_d;
            fail_q   <= fail_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            entry_q  <= entry_d;
            tries_q  <= tries_d;
            errcnt_q <= errcnt_d;
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        locked_d = locked_q;
        open_d   = 1'b0;
        fail_d   = 1'b0;
        err_d    = err_q;
        cnt_d    = cnt_q;
        entry_d  = entry_q;
        tries_d  = tries_q;
        errcnt_d = errcnt_q;

        if (stage_entry) begin
            // Fresh visit to a lock stage: full re-arm, any key this cycle is lost.
            fsm_d    = S_ENTRY;
            locked_d = 1'b1;
            err_d    = 1'b0;
            cnt_d    = 3'd0;
            entry_d  = 16'h0000;
            tries_d  = TRIES_INIT;
            errcnt_d = '0;
        end else if (!in_stage) begin
            fsm_d    = S_IDLE;
            locked_d = 1'b1;
            err_d    = 1'b0;
            tries_d  = TRIES_INIT;
        end else begin
            case (fsm_q)
                S_ENTRY: begin
                    if (cnt_q == 3'd4) begin
                        fsm_d = S_CHECK;
                    end else if (digit_key) begin
                        entry_d = {entry_q[11:0], key_code};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd3) begin
                            fsm_d = S_CHECK;
                        end
                    end else if (clear_key) begin
                        entry_d = 16'h0000;
                        cnt_d   = 3'd0;
                    end
                end
                S_CHECK: begin
                    if (entry_q == code_sel) begin
                        fsm_d    = S_OPEN;
                        locked_d = 1'b0;
                        open_d   = 1'b1;
                    end else if (tries_q <= 2'd1) begin
                        fsm_d   = S_FAILED;
                        tries_d = 2'd0;
                        fail_d  = 1'b1;
                    end else begin
                        fsm_d    = S_ERROR;
                        tries_d  = tries_q - 2'd1;
                        err_d    = 1'b1;
                        errcnt_d = '0;
                    end
                end
                S_OPEN: begin
                    locked_d = 1'b0;
                end
                S_ERROR: begin
                    if (errcnt_q == ERR_LAST) begin
                        fsm_d   = S_ENTRY;
                        err_d   = 1'b0;
                        entry_d = 16'h0000;
                        cnt_d   = 3'd0;
                    end else begin
                        errcnt_d = errcnt_q + 1'b1;
                    end
                end
                S_FAILED: begin
                    locked_d = 1'b1;
                end
                default: begin
                    fsm_d = S_IDLE;
                end
            endcase
        end
    end

    assign isLocked   = locked_q;
    assign door_open  = open_q;
    assign code_fail  = fail_q;
    assign err_flash  = err_q;
    assign digit_cnt  = cnt_q;
    assign entry      = entry_q;
    assign tries_left = tries_q;

endmodule

// File: tb/tb_door_lock_ctrl.sv
module tb_door_lock_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  state;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        isLocked;
    logic        door_open;
    logic        code_fail;
    logic        err_flash;
    logic [2:0]  digit_cnt;
    logic [15:0] entry;
    logic [1:0]  tries_left;

    int n_checks = 0;
    int n_fail   = 0;

    door_lock_ctrl #(
        .CODE1(16'h1234),
        .CODE2(16'h4071),
        .CODE3(16'h9527),
        .MAX_TRIES(3),
        .ERR_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .state(state),
        .key_valid(key_valid),
        .key_code(key_code),
        .isLocked(isLocked),
        .door_open(door_open),
        .code_fail(code_fail),
        .err_flash(err_flash),
        .digit_cnt(digit_cnt),
        .entry(entry),
        .tries_left(tries_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; outputs are then sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        state = 4'd0;
        tick();
        tick();
        n_checks++; if (isLocked !== 1'b1) begin $display("FAIL reset_locked: got %b want 1", isLocked); n_fail++; end
        n_checks++; if (tries_left !== 2'd3) begin $display("FAIL reset_tries: got %0d want 3", tries_left); n_fail++; end
        n_checks++; if (digit_cnt !== 3'd0) begin $display("FAIL reset_digits: got %0d want 0", digit_cnt); n_fail++; end
        n_checks++; if (entry !== 16'h0000) begin $display("FAIL reset_entry: got %h want 0000", entry); n_fail++; end
        n_checks++; if ({door_open, code_fail, err_flash} !== 3'b000) begin
            $display("FAIL reset_pulses: got %b want 000", {door_open, code_fail, err_flash}); n_fail++; end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_unlock();
        state = 4'd2;
        tick();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        n_checks++; if (entry !== 16'h1234) begin $display("FAIL unlock_entry: got %h want 1234", entry); n_fail++; end
        n_checks++; if (digit_cnt !== 3'd4) begin $display("FAIL unlock_digits: got %0d want 4", digit_cnt); n_fail++; end
        n_checks++; if (isLocked !== 1'b1) begin $display("FAIL unlock_still_locked_in_check: got %b want 1", isLocked); n_fail++; end
        tick();
        n_checks++; if (isLocked !== 1'b0) begin $display("FAIL unlock_open: got %b want 0", isLocked); n_fail++; end
        n_checks++; if (door_open !== 1'b1) begin $display("FAIL unlock_pulse_hi: got %b want 1", door_open); n_fail++; end
        tick();
        n_checks++; if (door_open !== 1'b0) begin $display("FAIL unlock_pulse_lo: got %b want 0", door_open); n_fail++; end
        press(4'd5);
        n_checks++; if (entry !== 16'h1234) begin $display("FAIL unlock_keys_ignored: got %h want 1234", entry); n_fail++; end
        n_checks++; if (isLocked !== 1'b0) begin $display("FAIL unlock_stays_open: got %b want 0", isLocked); n_fail++; end
    endtask

    task automatic test_error_window();
        int hi_cnt;
        state = 4'd4;
        tick();
        press(4'd1); press(4'd1); press(4'd1); press(4'd1);
        tick();
        n_checks++; if (tries_left !== 2'd2) begin $display("FAIL err_tries: got %0d want 2", tries_left); n_fail++; end
        n_checks++; if (isLocked !== 1'b1) begin $display("FAIL err_locked: got %b want 1", isLocked); n_fail++; end
        hi_cnt = (err_flash === 1'b1) ? 1 : 0;
        press(4'd7);
        if (err_flash === 1'b1) hi_cnt++;
        for (int i = 0; i < 20; i++) begin
            if (err_flash !== 1'b1) break;
            tick();
            if (err_flash === 1'b1) hi_cnt++;
        end
        n_checks++; if (hi_cnt !== 4) begin $display("FAIL err_window_len: got %0d want 4", hi_cnt); n_fail++; end
        n_checks++; if (digit_cnt !== 3'd0) begin $display("FAIL err_digits_cleared: got %0d want 0", digit_cnt); n_fail++; end
        n_checks++; if (entry !== 16'h0000) begin $display("FAIL err_entry_cleared: got %h want 0000", entry); n_fail++; end
        press(4'd4); press(4'd0); press(4'd7); press(4'd1);
        tick();
        n_checks++; if (door_open !== 1'b1) begin $display("FAIL err_then_unlock_pulse: got %b want 1", door_open); n_fail++; end
        n_checks++; if (isLocked !== 1'b0) begin $display("FAIL err_then_unlock: got %b want 0", isLocked); n_fail++; end
    endtask

    task automatic test_exhaust();
        int fail_pulses;
        logic [3:0] wrong [3];
        wrong[0] = 4'd0; wrong[1] = 4'd3; wrong[2] = 4'd8;
        state = 4'd6;
        tick();
        fail_pulses = 0;
        for (int a = 0; a < 3; a++) begin
            for (int d = 0; d < 4; d++) press(wrong[a]);
            tick();
            if (code_fail === 1'b1) fail_pulses++;
            if (a < 2) begin
                for (int i = 0; i < 10; i++) begin
                    if (err_flash !== 1'b1) break;
                    tick();
                    if (code_fail === 1'b1) fail_pulses++;
                end
            end else begin
                n_checks++; if (code_fail !== 1'b1) begin $display("FAIL exhaust_pulse_on_third: got %b want 1", code_fail); n_fail++; end
                n_checks++; if (tries_left !== 2'd0) begin $display("FAIL exhaust_tries: got %0d want 0", tries_left); n_fail++; end
                n_checks++; if (err_flash !== 1'b0) begin $display("FAIL exhaust_no_flash: got %b want 0", err_flash); n_fail++; end
            end
        end
        press(4'd9); if (code_fail === 1'b1) fail_pulses++;
        press(4'd5); if (code_fail === 1'b1) fail_pulses++;
        press(4'd2); if (code_fail === 1'b1) fail_pulses++;
        press(4'd7); if (code_fail === 1'b1) fail_pulses++;
        tick();
        n_checks++; if (fail_pulses !== 1) begin $display("FAIL exhaust_pulse_count: got %0d want 1", fail_pulses); n_fail++; end
        tick();
        n_checks++; if (isLocked !== 1'b1) begin $display("FAIL exhaust_locked: got %b want 1", isLocked); n_fail++; end
        n_checks++; if (door_open !== 1'b0) begin $display("FAIL exhaust_no_open: got %b want 0", door_open); n_fail++; end
        n_checks++; if (entry !== 16'h8888) begin $display("FAIL exhaust_keys_ignored: got %h want 8888", entry); n_fail++; end
    endtask

    task automatic test_clear();
        state = 4'd2;
        tick();
        press(4'd5); press(4'd6);
        press(4'hA);
        n_checks++; if (digit_cnt !== 3'd2) begin $display("FAIL clear_ignore_a_cnt: got %0d want 2", digit_cnt); n_fail++; end
        n_checks++; if (entry !== 16'h0056) begin $display("FAIL clear_ignore_a_entry: got %h want 0056", entry); n_fail++; end
        press(4'hC);
        n_checks++; if (digit_cnt !== 3'd0) begin $display("FAIL clear_cnt: got %0d want 0", digit_cnt); n_fail++; end
        n_checks++; if (entry !== 16'h0000) begin $display("FAIL clear_entry: got %h want 0000", entry); n_fail++; end
        press(4'd1); press(4'd2); press(4'hA); press(4'd3); press(4'd4);
        n_checks++; if (entry !== 16'h1234) begin $display("FAIL clear_reentry: got %h want 1234", entry); n_fail++; end
        tick();
        n_checks++; if (isLocked !== 1'b0) begin $display("FAIL clear_unlock: got %b want 0", isLocked); n_fail++; end
    endtask

    task automatic test_reenter();
        state = 4'd3;
        tick();
        n_checks++; if (isLocked !== 1'b1) begin $display("FAIL reenter_leave_locked: got %b want 1", isLocked); n_fail++; end
        state     = 4'd2;
        key_valid = 1'b1;
        key_code  = 4'd5;
        tick();
        key_valid = 1'b0;
        n_checks++; if (isLocked !== 1'b1) begin $display("FAIL reenter_locked: got %b want 1", isLocked); n_fail++; end
        n_checks++; if (tries_left !== 2'd3) begin $display("FAIL reenter_tries: got %0d want 3", tries_left); n_fail++; end
        n_checks++; if (digit_cnt !== 3'd0) begin $display("FAIL reenter_key_dropped: got %0d want 0", digit_cnt); n_fail++; end
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        tick();
        n_checks++; if (isLocked !== 1'b0) begin $display("FAIL reenter_unlock: got %b want 0", isLocked); n_fail++; end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (isLocked !== 1'b1) begin $display("FAIL reset_in_open: got %b want 1", isLocked); n_fail++; end
    endtask

    initial begin
        rst_n     = 1'b0;
        state     = 4'd0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        test_reset();
        test_unlock();
        test_error_window();
        test_exhaust();
        test_clear();
        test_reenter();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
